// File: rtl/ram_read_streamer.sv
// Burst read streamer: turns a (base, len) command into a run of single-cycle
// RAM reads and streams the returned words out through a small credit-guarded FIFO.
module ram_read_streamer #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic                  s_read_req,
  output logic [ADDR_WIDTH-1:0] s_read_addr,
  input  logic [DATA_WIDTH-1:0] s_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 2;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] issue_cnt_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       fifo_count_q;

  logic push;
  logic pop;
  logic credit;
  logic issue_last;

  assign pop        = m_valid & m_ready;
  assign push       = inflight_q;
  // A new request may only go out if its word is guaranteed a FIFO slot,
  // counting the word already on its way back from the RAM.
  assign credit     = (fifo_count_q + CntW'(inflight_q)) < (CntW'(FIFO_DEPTH) + CntW'(pop));
  assign issue_last = (issue_cnt_q == len_q);

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign s_read_req  = (state_q == StIssue) & credit;
  assign s_read_addr = (state_q == StIssue) ? (base_q + issue_cnt_q) : '0;

  assign m_valid = (fifo_count_q != '0);
  assign m_data  = fifo_data_q[rd_ptr_q];
  assign m_last  = fifo_last_q[rd_ptr_q];

  // Burst control FSM: accept command, issue reads, wait for last word to leave.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            base_q      <= cmd_base_addr;
            len_q       <= cmd_len;
            issue_cnt_q <= '0;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (s_read_req) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
            if (issue_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && m_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Track the single outstanding RAM read and whether it carries the last tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= s_read_req;
      inflight_last_q <= s_read_req & issue_last;
    end
  end

  // Output FIFO: storage is cleared on reset so m_data/m_last read back as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_data_q[i] <= '0;
      fifo_last_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= s_read_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_streamer.sv
// Self-checking bench for ram_read_streamer with a one-cycle-latency RAM model
// holding mem[a] = a (truncated to the data width).
module tb_ram_read_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_base_addr = '0;
  logic [11:0] cmd_len = '0;
  logic        s_read_req;
  logic [11:0] s_read_addr;
  logic [9:0]  s_read_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [9:0]  m_data;
  logic        m_last;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [10:0] exp_q[$];
  logic [11:0] addr_log[$];

  ram_read_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base_addr (cmd_base_addr),
    .cmd_len       (cmd_len),
    .s_read_req    (s_read_req),
    .s_read_addr   (s_read_addr),
    .s_read_data   (s_read_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // RAM model: data appears one cycle after the strobe and is held otherwise.
  always @(posedge clk) if (s_read_req) s_read_data <= s_read_addr[9:0];

  // Offer a command, queue its expected words, return once the handshake edge passed.
  task automatic send_cmd(input logic [11:0] b, input logic [11:0] l, output bit ok);
    logic [11:0] a;
    cmd_valid = 1'b1; cmd_base_addr = b; cmd_len = l;
    for (int i = 0; i <= int'(l); i++) begin
      a = b + 12'(i);
      exp_q.push_back({(i == int'(l)), a[9:0]});
    end
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Run cycles after a handshake (cycle 1 onward), popping the scoreboard on each
  // output handshake. mode 0: m_ready always high; mode 1: high one cycle in three.
  task automatic stream(input int mode, input int n_words, input int stop_after,
                        output int first_req, output int first_cyc, output int last_cyc,
                        output int max_cnt, output int stalls, output int busy_cyc);
    logic [10:0] e;
    int nreq, npop, c;
    first_req = -1; first_cyc = -1; last_cyc = -1;
    max_cnt = 0; stalls = 0; busy_cyc = 0; nreq = 0; npop = 0;
    for (c = 1; c <= 100 && exp_q.size() != 0 && (stop_after == 0 || npop < stop_after); c++) begin
      m_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      @(negedge clk);
      if (busy) busy_cyc++;
      if (s_read_req) begin
        addr_log.push_back(s_read_addr);
        if (first_req < 0) first_req = c;
        nreq++;
      end else if (nreq < n_words) stalls++;
      if (int'(dut.fifo_count_q) > max_cnt) max_cnt = int'(dut.fifo_count_q);
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        npop++;
        n_checks++;
        if ({m_last, m_data} !== e) begin
          n_fail++;
          $display("FAIL stream_word cyc %0d: got last=%b data=%h, want last=%b data=%h",
                   c, m_last, m_data, e[10], e[9:0]);
        end
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    if (stop_after == 0) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL stream_timeout: got %0d words outstanding, want 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if ({cmd_ready, s_read_req, s_read_addr, m_valid, m_data, m_last, busy} !==
        {1'b1, 1'b0, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b req=%b addr=%h mv=%b md=%h ml=%b busy=%b, want 1 0 000 0 000 0 0",
               tag, cmd_ready, s_read_req, s_read_addr, m_valid, m_data, m_last, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_values");
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("idle_after_release");
  endtask

  task automatic test_basic();
    bit ok; int fr, fc, lc, mc, st, bc;
    send_cmd(12'h010, 12'd7, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_handshake: got no cmd_ready, want accept"); end
    addr_log.delete();
    stream(0, 8, 0, fr, fc, lc, mc, st, bc);
    n_checks++;
    if (fr != 1) begin n_fail++; $display("FAIL basic_req_cycle: got %0d, want 1", fr); end
    n_checks++;
    if (fc != 3 || lc != 10) begin
      n_fail++; $display("FAIL basic_word_cycles: got %0d..%0d, want 3..10", fc, lc);
    end
    @(negedge clk);
    n_checks++;
    if (!cmd_ready || busy) begin
      n_fail++; $display("FAIL basic_release: got rdy=%b busy=%b, want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_wrap();
    bit ok; int fr, fc, lc, mc, st, bc;
    logic [11:0] want[4];
    want[0] = 12'hFFE; want[1] = 12'hFFF; want[2] = 12'h000; want[3] = 12'h001;
    send_cmd(12'hFFE, 12'd3, ok);
    addr_log.delete();
    stream(0, 4, 0, fr, fc, lc, mc, st, bc);
    n_checks++;
    if (addr_log.size() != 4) begin
      n_fail++; $display("FAIL wrap_req_count: got %0d, want 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (addr_log[i] !== want[i]) begin
          n_fail++; $display("FAIL wrap_addr[%0d]: got %h, want %h", i, addr_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_throttle();
    bit ok; int fr, fc, lc, mc, st, bc;
    send_cmd(12'h300, 12'd15, ok);
    addr_log.delete();
    stream(1, 16, 0, fr, fc, lc, mc, st, bc);
    n_checks++;
    if (mc > 4) begin n_fail++; $display("FAIL throttle_fifo_max: got %0d, want <=4", mc); end
    n_checks++;
    if (st == 0) begin n_fail++; $display("FAIL throttle_stall: got 0 stall cycles, want >0"); end
    n_checks++;
    if (addr_log.size() != 16) begin
      n_fail++; $display("FAIL throttle_req_count: got %0d, want 16", addr_log.size());
    end
  endtask

  task automatic test_len0();
    bit ok; int fr, fc, lc, mc, st, bc;
    send_cmd(12'h055, 12'd0, ok);
    stream(0, 1, 0, fr, fc, lc, mc, st, bc);
    n_checks++;
    if (fc != 3 || lc != 3) begin
      n_fail++; $display("FAIL len0_word_cycle: got %0d..%0d, want 3..3", fc, lc);
    end
    // Busy over cycles 1..3; together with the handshake cycle that is 4 cycles.
    n_checks++;
    if (bc != 3) begin n_fail++; $display("FAIL len0_busy_cycles: got %0d, want 3", bc); end
    @(negedge clk);
    n_checks++;
    if (!cmd_ready || busy) begin
      n_fail++; $display("FAIL len0_release: got rdy=%b busy=%b, want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok; int fr, fc, lc, mc, st, bc;
    send_cmd(12'h200, 12'd9, ok);
    stream(0, 10, 3, fr, fc, lc, mc, st, bc);
    #2 reset = 1'b1;
    #1 check_idle_outputs("reset_async_mid_burst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    send_cmd(12'h100, 12'd1, ok);
    stream(0, 2, 0, fr, fc, lc, mc, st, bc);
    n_checks++;
    if (fc != 3 || lc != 4) begin
      n_fail++; $display("FAIL post_reset_cycles: got %0d..%0d, want 3..4", fc, lc);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_extra_word: got m_valid=%b data=%h, want 0", m_valid, m_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a;
    logic [10:0] e;
    int acc_cyc, a_last;
    bit got;
    cmd_valid = 1'b1; cmd_base_addr = 12'h040; cmd_len = 12'd2;
    for (int i = 0; i < 3; i++) begin a = 12'h040 + 12'(i); exp_q.push_back({(i == 2), a[9:0]}); end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    cmd_base_addr = 12'h080; cmd_len = 12'd1;
    for (int i = 0; i < 2; i++) begin a = 12'h080 + 12'(i); exp_q.push_back({(i == 1), a[9:0]}); end
    acc_cyc = -1; a_last = -1;
    for (int c = 1; c <= 40 && (acc_cyc < 0 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (cmd_ready && acc_cyc < 0) acc_cyc = c;
      if (m_valid && m_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({m_last, m_data} !== e) begin
          n_fail++;
          $display("FAIL b2b_word cyc %0d: got last=%b data=%h, want last=%b data=%h",
                   c, m_last, m_data, e[10], e[9:0]);
        end
        if (m_last && a_last < 0) a_last = c;
      end
      @(posedge clk); #1;
      if (acc_cyc == c) cmd_valid = 1'b0;
    end
    n_checks++;
    if (a_last != 5 || acc_cyc != a_last + 1) begin
      n_fail++; $display("FAIL b2b_second_accept: got accept %0d after last %0d, want 6 after 5",
                         acc_cyc, a_last);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d words outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_throttle();
    test_len0();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
